// File: rtl/mem_bus_arbiter_pkg.sv
// Shared bus types for the processor-memory port: bus commands, tag owners
// and the tag-table entry layout.
package mem_bus_arbiter_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned NUM_MEM_TAGS = 16;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic {
    OWNER_ICACHE = 1'b0,
    OWNER_DCACHE = 1'b1
  } MEM_OWNER;

  typedef struct packed {
    logic     valid;
    MEM_OWNER owner;
  } MEM_TAG_ENTRY;

endpackage

// File: rtl/mem_bus_arbiter_tag_table.sv
// Outstanding-load tag table: records which cache owns each accepted load tag
// and frees the entry when its data returns.
module mem_tag_table
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_TAGS = NUM_MEM_TAGS,
  parameter int unsigned TAG_W    = $clog2(NUM_TAGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_en,
  input  logic [TAG_W-1:0] alloc_tag,
  input  MEM_OWNER         alloc_owner,
  input  logic [TAG_W-1:0] ret_tag,
  output logic             ret_valid,
  output MEM_OWNER         ret_owner
);

  MEM_TAG_ENTRY tbl_q [NUM_TAGS];

  assign ret_valid = (ret_tag != '0) && tbl_q[ret_tag].valid;
  assign ret_owner = tbl_q[ret_tag].owner;

  // Free is written before allocate so a same-cycle reuse of a tag keeps the new owner.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_TAGS; i++) begin
        tbl_q[i] <= '0;
      end
    end else begin
      if (ret_tag != '0) begin
        tbl_q[ret_tag].valid <= 1'b0;
      end
      if (alloc_en) begin
        tbl_q[alloc_tag] <= '{valid: 1'b1, owner: alloc_owner};
      end
    end
  end

  // The memory model must never hand out a tag that is still outstanding.
  tag_overwrite_chk: assert property (@(posedge clock) disable iff (!reset)
    !(alloc_en && tbl_q[alloc_tag].valid && (ret_tag != alloc_tag)));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the processor-memory port between Icache and Dcache: Dcache-priority
// arbitration with an Icache starvation guard, plus tag-based return routing.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned NUM_TAGS     = NUM_MEM_TAGS
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            icache_req,
  input  logic [XLEN-1:0] icache_addr,
  output logic            icache_gnt,
  output logic [3:0]      icache_resp_tag,
  output logic [3:0]      icache_data_tag,
  output logic [63:0]     icache_data,
  input  logic            dcache_req,
  input  logic [1:0]      dcache_cmd,
  input  logic [XLEN-1:0] dcache_addr,
  input  logic [63:0]     dcache_wdata,
  output logic            dcache_gnt,
  output logic [3:0]      dcache_resp_tag,
  output logic [3:0]      dcache_data_tag,
  output logic [63:0]     dcache_data,
  output logic [1:0]      proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [63:0]     proc2mem_data,
  input  logic [3:0]      mem2proc_response,
  input  logic [63:0]     mem2proc_data,
  input  logic [3:0]      mem2proc_tag,
  output logic            spurious_tag
);

  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

  logic       [2:0] starve_cnt;
  logic             sel_i, sel_d, accepted;
  logic             alloc_en;
  MEM_OWNER         alloc_owner;
  logic             ret_valid;
  MEM_OWNER         ret_owner;
  BUS_COMMAND       d_cmd;

  assign d_cmd    = BUS_COMMAND'(dcache_cmd);
  assign accepted = (mem2proc_response != 4'd0);
  assign sel_i    = icache_req && (!dcache_req || (starve_cnt == STARVE_MAX));
  assign sel_d    = dcache_req && !sel_i;

  // Every output is forced to zero while reset is held, even though the path is combinational.
  always_comb begin
    icache_gnt       = 1'b0;
    icache_resp_tag  = '0;
    icache_data_tag  = '0;
    icache_data      = '0;
    dcache_gnt       = 1'b0;
    dcache_resp_tag  = '0;
    dcache_data_tag  = '0;
    dcache_data      = '0;
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    spurious_tag     = 1'b0;
    alloc_en         = 1'b0;
    alloc_owner      = OWNER_ICACHE;
    if (reset) begin
      if (sel_i) begin
        proc2mem_command = BUS_LOAD;
        proc2mem_addr    = icache_addr;
        icache_gnt       = accepted;
        icache_resp_tag  = accepted ? mem2proc_response : '0;
        alloc_en         = accepted;
      end else if (sel_d) begin
        proc2mem_command = d_cmd;
        proc2mem_addr    = dcache_addr;
        proc2mem_data    = (d_cmd == BUS_STORE) ? dcache_wdata : '0;
        dcache_gnt       = accepted;
        dcache_resp_tag  = accepted ? mem2proc_response : '0;
        alloc_en         = accepted && (d_cmd == BUS_LOAD);
        alloc_owner      = OWNER_DCACHE;
      end
      if (mem2proc_tag != 4'd0) begin
        if (!ret_valid) begin
          spurious_tag = 1'b1;
        end else if (ret_owner == OWNER_ICACHE) begin
          icache_data_tag = mem2proc_tag;
          icache_data     = mem2proc_data;
        end else begin
          dcache_data_tag = mem2proc_tag;
          dcache_data     = mem2proc_data;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!icache_req || icache_gnt) begin
      starve_cnt <= '0;
    end else if (dcache_gnt && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 3'd1;
    end
  end

  mem_tag_table #(
    .NUM_TAGS (NUM_TAGS),
    .TAG_W    (4)
  ) u_tag_table (
    .clock       (clock),
    .reset       (reset),
    .alloc_en    (alloc_en),
    .alloc_tag   (mem2proc_response),
    .alloc_owner (alloc_owner),
    .ret_tag     (mem2proc_tag),
    .ret_valid   (ret_valid),
    .ret_owner   (ret_owner)
  );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: hand-computed vectors covering
// arbitration, starvation guard, rejection, tag routing and reset.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic            clock = 1'b0;
  logic            reset;
  logic            icache_req;
  logic [XLEN-1:0] icache_addr;
  logic            icache_gnt;
  logic [3:0]      icache_resp_tag, icache_data_tag;
  logic [63:0]     icache_data;
  logic            dcache_req;
  logic [1:0]      dcache_cmd;
  logic [XLEN-1:0] dcache_addr;
  logic [63:0]     dcache_wdata;
  logic            dcache_gnt;
  logic [3:0]      dcache_resp_tag, dcache_data_tag;
  logic [63:0]     dcache_data;
  logic [1:0]      proc2mem_command;
  logic [XLEN-1:0] proc2mem_addr;
  logic [63:0]     proc2mem_data;
  logic [3:0]      mem2proc_response;
  logic [63:0]     mem2proc_data;
  logic [3:0]      mem2proc_tag;
  logic            spurious_tag;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  always #5 clock = ~clock;

  mem_bus_arbiter #(
    .STARVE_LIMIT (4),
    .NUM_TAGS     (16)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .icache_req        (icache_req),
    .icache_addr       (icache_addr),
    .icache_gnt        (icache_gnt),
    .icache_resp_tag   (icache_resp_tag),
    .icache_data_tag   (icache_data_tag),
    .icache_data       (icache_data),
    .dcache_req        (dcache_req),
    .dcache_cmd        (dcache_cmd),
    .dcache_addr       (dcache_addr),
    .dcache_wdata      (dcache_wdata),
    .dcache_gnt        (dcache_gnt),
    .dcache_resp_tag   (dcache_resp_tag),
    .dcache_data_tag   (dcache_data_tag),
    .dcache_data       (dcache_data),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .proc2mem_data     (proc2mem_data),
    .mem2proc_response (mem2proc_response),
    .mem2proc_data     (mem2proc_data),
    .mem2proc_tag      (mem2proc_tag),
    .spurious_tag      (spurious_tag)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    icache_req = 1'b0; icache_addr = '0;
    dcache_req = 1'b0; dcache_cmd = 2'd0; dcache_addr = '0; dcache_wdata = '0;
    mem2proc_response = '0; mem2proc_data = '0; mem2proc_tag = '0;
  endtask

  // Advance one cycle; inputs change 1 time unit after the edge, checks run 3 units later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset with activity on every input: outputs must stay zero
    idle();
    reset = 1'b0;
    icache_req = 1'b1; icache_addr = 32'h100; mem2proc_response = 4'd3;
    mem2proc_tag = 4'd3; mem2proc_data = 64'h11;
    #2;
    chk("rst_icache_gnt", 64'(icache_gnt), 64'd0);
    chk("rst_icache_resp_tag", 64'(icache_resp_tag), 64'd0);
    chk("rst_command", 64'(proc2mem_command), 64'd0);
    chk("rst_addr", 64'(proc2mem_addr), 64'd0);
    chk("rst_spurious", 64'(spurious_tag), 64'd0);
    tick(); tick();
    reset = 1'b1; idle();
    #3;
    chk("idle_command", 64'(proc2mem_command), 64'(BUS_NONE));
    chk("idle_addr", 64'(proc2mem_addr), 64'd0);

    // 1: Icache-only load, then data return on tag 3
    tick();
    icache_req = 1'b1; icache_addr = 32'h100; mem2proc_response = 4'd3;
    #3;
    chk("t1_command", 64'(proc2mem_command), 64'(BUS_LOAD));
    chk("t1_addr", 64'(proc2mem_addr), 64'h100);
    chk("t1_data", proc2mem_data, 64'd0);
    chk("t1_icache_gnt", 64'(icache_gnt), 64'd1);
    chk("t1_icache_resp_tag", 64'(icache_resp_tag), 64'd3);
    chk("t1_dcache_gnt", 64'(dcache_gnt), 64'd0);
    tick(); idle();
    mem2proc_tag = 4'd3; mem2proc_data = 64'hDEAD;
    #3;
    chk("t1_icache_data_tag", 64'(icache_data_tag), 64'd3);
    chk("t1_icache_data", icache_data, 64'hDEAD);
    chk("t1_dcache_data_tag", 64'(dcache_data_tag), 64'd0);
    chk("t1_dcache_data", dcache_data, 64'd0);
    chk("t1_no_spurious", 64'(spurious_tag), 64'd0);
    tick();
    #3;
    chk("t1_tag3_freed", 64'(spurious_tag), 64'd1);
    chk("t1_freed_no_route", 64'(icache_data_tag), 64'd0);

    // 2: Both requesting, Dcache stores win four times, Icache forced on the fifth
    tick(); idle();
    icache_req = 1'b1; icache_addr = 32'h200;
    dcache_req = 1'b1; dcache_cmd = 2'(BUS_STORE); dcache_addr = 32'h300; dcache_wdata = 64'h55;
    mem2proc_response = 4'd5;
    for (int unsigned c = 1; c <= 4; c++) begin
      #3;
      chk($sformatf("t2_c%0d_dcache_gnt", c), 64'(dcache_gnt), 64'd1);
      chk($sformatf("t2_c%0d_icache_gnt", c), 64'(icache_gnt), 64'd0);
      chk($sformatf("t2_c%0d_addr", c), 64'(proc2mem_addr), 64'h300);
      tick();
    end
    #3;
    chk("t2_c5_icache_gnt", 64'(icache_gnt), 64'd1);
    chk("t2_c5_icache_resp_tag", 64'(icache_resp_tag), 64'd5);
    chk("t2_c5_dcache_gnt", 64'(dcache_gnt), 64'd0);
    chk("t2_c5_command", 64'(proc2mem_command), 64'(BUS_LOAD));
    chk("t2_c5_addr", 64'(proc2mem_addr), 64'h200);
    chk("t2_c5_data", proc2mem_data, 64'd0);
    tick();
    #3;
    chk("t2_starve_cleared", 64'(dut.starve_cnt), 64'd0);
    chk("t2_c6_dcache_gnt", 64'(dcache_gnt), 64'd1);
    tick(); idle();
    mem2proc_tag = 4'd5; mem2proc_data = 64'h5555;
    #3;
    chk("t2_ret_icache_tag", 64'(icache_data_tag), 64'd5);
    chk("t2_ret_icache_data", icache_data, 64'h5555);

    // 3: Dcache store takes tag 7 but owns nothing; tag 7 returning is spurious
    tick(); idle();
    dcache_req = 1'b1; dcache_cmd = 2'(BUS_STORE); dcache_addr = 32'h40; dcache_wdata = 64'h1234;
    mem2proc_response = 4'd7;
    #3;
    chk("t3_command", 64'(proc2mem_command), 64'(BUS_STORE));
    chk("t3_addr", 64'(proc2mem_addr), 64'h40);
    chk("t3_data", proc2mem_data, 64'h1234);
    chk("t3_dcache_gnt", 64'(dcache_gnt), 64'd1);
    chk("t3_dcache_resp_tag", 64'(dcache_resp_tag), 64'd7);
    tick(); idle();
    mem2proc_tag = 4'd7; mem2proc_data = 64'h99;
    #3;
    chk("t3_spurious", 64'(spurious_tag), 64'd1);
    chk("t3_icache_data_tag", 64'(icache_data_tag), 64'd0);
    chk("t3_dcache_data_tag", 64'(dcache_data_tag), 64'd0);
    chk("t3_dcache_data", dcache_data, 64'd0);

    // 4: Icache rejected three cycles, accepted as tag 2 on the fourth
    tick(); idle();
    icache_req = 1'b1; icache_addr = 32'h80;
    for (int unsigned c = 1; c <= 3; c++) begin
      #3;
      chk($sformatf("t4_c%0d_gnt", c), 64'(icache_gnt), 64'd0);
      chk($sformatf("t4_c%0d_resp_tag", c), 64'(icache_resp_tag), 64'd0);
      chk($sformatf("t4_c%0d_command", c), 64'(proc2mem_command), 64'(BUS_LOAD));
      tick();
    end
    mem2proc_response = 4'd2;
    #3;
    chk("t4_gnt", 64'(icache_gnt), 64'd1);
    chk("t4_resp_tag", 64'(icache_resp_tag), 64'd2);
    chk("t4_command", 64'(proc2mem_command), 64'(BUS_LOAD));
    tick(); idle();
    mem2proc_tag = 4'd2; mem2proc_data = 64'h22;
    #3;
    chk("t4_ret_icache_tag", 64'(icache_data_tag), 64'd2);

    // 5: Tag 4 returns to Icache in the same cycle a Dcache load is accepted as tag 4
    tick(); idle();
    icache_req = 1'b1; icache_addr = 32'h500; mem2proc_response = 4'd4;
    #3;
    chk("t5_icache_gnt", 64'(icache_gnt), 64'd1);
    tick(); idle();
    dcache_req = 1'b1; dcache_cmd = 2'(BUS_LOAD); dcache_addr = 32'h600; mem2proc_response = 4'd4;
    mem2proc_tag = 4'd4; mem2proc_data = 64'hCAFE;
    #3;
    chk("t5_icache_data_tag", 64'(icache_data_tag), 64'd4);
    chk("t5_icache_data", icache_data, 64'hCAFE);
    chk("t5_dcache_data_tag", 64'(dcache_data_tag), 64'd0);
    chk("t5_dcache_gnt", 64'(dcache_gnt), 64'd1);
    chk("t5_dcache_resp_tag", 64'(dcache_resp_tag), 64'd4);
    chk("t5_no_spurious", 64'(spurious_tag), 64'd0);
    tick(); idle();
    mem2proc_tag = 4'd4; mem2proc_data = 64'hBEEF;
    #3;
    chk("t5_dcache_owns_tag", 64'(dcache_data_tag), 64'd4);
    chk("t5_dcache_data", dcache_data, 64'hBEEF);
    chk("t5_icache_not_routed", 64'(icache_data_tag), 64'd0);

    // 6: Icache load outstanding as tag 6, reset pulsed, tag 6 then returns
    tick(); idle();
    icache_req = 1'b1; icache_addr = 32'h700; mem2proc_response = 4'd6;
    #3;
    chk("t6_icache_gnt", 64'(icache_gnt), 64'd1);
    tick();
    reset = 1'b0;
    icache_req = 1'b1; mem2proc_response = 4'd9;
    mem2proc_tag = 4'd6; mem2proc_data = 64'h77;
    #3;
    chk("t6_rst_icache_gnt", 64'(icache_gnt), 64'd0);
    chk("t6_rst_icache_data_tag", 64'(icache_data_tag), 64'd0);
    chk("t6_rst_icache_data", icache_data, 64'd0);
    chk("t6_rst_spurious", 64'(spurious_tag), 64'd0);
    chk("t6_rst_command", 64'(proc2mem_command), 64'd0);
    tick();
    reset = 1'b1; idle();
    mem2proc_tag = 4'd6; mem2proc_data = 64'h66;
    #3;
    chk("t6_spurious", 64'(spurious_tag), 64'd1);
    chk("t6_icache_data_tag", 64'(icache_data_tag), 64'd0);
    chk("t6_icache_data", icache_data, 64'd0);
    tick(); idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
